// File: rtl/pipelined_control_unit.sv
// pipelined_control_unit: ID decode, load-use hazard/flush control and ID/EX, EX/MEM, MEM/WB control registers
module pipelined_control_unit #(
  parameter int REG_ADDR_W       = 5,
  parameter int ALUOP_W          = 2,
  parameter int LOAD_USE_BUBBLES = 1,
  parameter int ENABLE_JUMP      = 1,
  parameter int CNT_W            = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  id_valid,
  input  logic [6:0]            id_opcode,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic [REG_ADDR_W-1:0] id_rd,
  input  logic                  branch_taken,
  output logic                  stall,
  output logic                  flush,
  output logic                  ex_alusrc,
  output logic                  ex_branch,
  output logic                  ex_jump,
  output logic                  ex_memread,
  output logic                  ex_memwrite,
  output logic [ALUOP_W-1:0]    ex_aluop,
  output logic [REG_ADDR_W-1:0] ex_rd,
  output logic [REG_ADDR_W-1:0] mem_rd,
  output logic [REG_ADDR_W-1:0] wb_rd,
  output logic                  mem_memread,
  output logic                  mem_memwrite,
  output logic                  mem_regwrite,
  output logic                  wb_regwrite,
  output logic                  wb_memtoreg,
  output logic [CNT_W-1:0]      stall_count
);
  typedef struct packed {
    logic       alusrc;
    logic       memtoreg;
    logic       regwrite;
    logic       memread;
    logic       memwrite;
    logic       branch;
    logic       jump;
    logic [1:0] aluop;
  } ctrl_t;

  ctrl_t                  dec, id_c, ex_c;
  logic                   rs1u, rs2u, ex_hit, mem_hit, guard, mem_memtoreg;
  logic [REG_ADDR_W-1:0]  dec_rd;

  always_comb begin
    dec  = '0;
    rs1u = 1'b0;
    rs2u = 1'b0;
    if (id_valid)
      case (id_opcode)
        7'b0000011: begin dec = 9'b1_1_1_1_0_0_0_00; rs1u = 1'b1; end
        7'b0100011: begin dec = 9'b1_0_0_0_1_0_0_00; rs1u = 1'b1; rs2u = 1'b1; end
        7'b0110011: begin dec = 9'b0_0_1_0_0_0_0_10; rs1u = 1'b1; rs2u = 1'b1; end
        7'b1100011: begin dec = 9'b0_0_0_0_0_1_0_01; rs1u = 1'b1; rs2u = 1'b1; end
        7'b0010011: begin dec = 9'b1_0_1_0_0_0_0_00; rs1u = 1'b1; end
        7'b1101111: if (ENABLE_JUMP != 0) dec = 9'b0_0_1_0_0_0_1_00;
        7'b1100111: if (ENABLE_JUMP != 0) begin dec = 9'b1_0_1_0_0_0_1_00; rs1u = 1'b1; end
        7'b0110111: if (ENABLE_JUMP != 0) dec = 9'b1_0_1_0_0_0_0_11;
        7'b0010111: if (ENABLE_JUMP != 0) dec = 9'b1_0_1_0_0_0_0_11;
        default: ;
      endcase
    id_c          = dec;
    id_c.regwrite = dec.regwrite && (id_rd != '0);
    dec_rd        = (dec != '0) ? id_rd : '0;
  end

  // A load only blocks the consumer if the ID instruction actually reads the matching source
  assign ex_hit  = ex_memread && (ex_rd != '0) &&
                   ((rs1u && ex_rd == id_rs1) || (rs2u && ex_rd == id_rs2));
  assign mem_hit = (LOAD_USE_BUBBLES == 2) && mem_memread && (mem_rd != '0) &&
                   ((rs1u && mem_rd == id_rs1) || (rs2u && mem_rd == id_rs2));
  assign stall   = !branch_taken && (ex_hit || mem_hit);
  assign flush   = branch_taken;
  assign guard   = branch_taken && !ex_c.jump && !ex_c.branch;

  assign ex_alusrc   = ex_c.alusrc;
  assign ex_branch   = ex_c.branch;
  assign ex_jump     = ex_c.jump;
  assign ex_memread  = ex_c.memread;
  assign ex_memwrite = ex_c.memwrite;
  assign ex_aluop    = ALUOP_W'(ex_c.aluop);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ex_c         <= '0;
      ex_rd        <= '0;
      mem_memread  <= 1'b0;
      mem_memwrite <= 1'b0;
      mem_regwrite <= 1'b0;
      mem_memtoreg <= 1'b0;
      mem_rd       <= '0;
      wb_regwrite  <= 1'b0;
      wb_memtoreg  <= 1'b0;
      wb_rd        <= '0;
      stall_count  <= '0;
    end else begin
      ex_c         <= (stall || branch_taken) ? '0 : id_c;
      ex_rd        <= (stall || branch_taken) ? '0 : dec_rd;
      mem_memread  <= !guard && ex_c.memread;
      mem_memwrite <= !guard && ex_c.memwrite;
      mem_regwrite <= !guard && ex_c.regwrite && (ex_rd != '0);
      mem_memtoreg <= !guard && ex_c.memtoreg;
      mem_rd       <= guard ? '0 : ex_rd;
      wb_regwrite  <= mem_regwrite && (mem_rd != '0);
      wb_memtoreg  <= mem_memtoreg;
      wb_rd        <= mem_rd;
      if (stall && stall_count != '1) stall_count <= stall_count + 1'b1;
    end
  end
endmodule

// File: tb/tb_pipelined_control_unit.sv
// tb_pipelined_control_unit: directed vectors against a default instance (a) and a
// LOAD_USE_BUBBLES=2, ENABLE_JUMP=0, CNT_W=2 instance (b) sharing the same inputs
module tb_pipelined_control_unit;
  localparam logic [6:0] LD = 7'b0000011, ST = 7'b0100011, RT = 7'b0110011, BR = 7'b1100011,
                         IA = 7'b0010011, JAL = 7'b1101111, LUI = 7'b0110111;

  logic clk, reset, id_valid, branch_taken;
  logic [6:0] id_opcode;
  logic [4:0] id_rs1, id_rs2, id_rd;
  int vectors = 0, miscompares = 0;

  logic a_stall, a_flush, a_ex_alusrc, a_ex_branch, a_ex_jump, a_ex_memread, a_ex_memwrite;
  logic a_mem_memread, a_mem_memwrite, a_mem_regwrite, a_wb_regwrite, a_wb_memtoreg;
  logic [1:0] a_ex_aluop;
  logic [4:0] a_ex_rd, a_mem_rd, a_wb_rd;
  logic [15:0] a_stall_count;

  logic b_stall, b_flush, b_ex_alusrc, b_ex_branch, b_ex_jump, b_ex_memread, b_ex_memwrite;
  logic b_mem_memread, b_mem_memwrite, b_mem_regwrite, b_wb_regwrite, b_wb_memtoreg;
  logic [1:0] b_ex_aluop;
  logic [4:0] b_ex_rd, b_mem_rd, b_wb_rd;
  logic [1:0] b_stall_count;

  pipelined_control_unit dut_a (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_opcode(id_opcode), .id_rs1(id_rs1),
    .id_rs2(id_rs2), .id_rd(id_rd), .branch_taken(branch_taken), .stall(a_stall), .flush(a_flush),
    .ex_alusrc(a_ex_alusrc), .ex_branch(a_ex_branch), .ex_jump(a_ex_jump), .ex_memread(a_ex_memread),
    .ex_memwrite(a_ex_memwrite), .ex_aluop(a_ex_aluop), .ex_rd(a_ex_rd), .mem_rd(a_mem_rd),
    .wb_rd(a_wb_rd), .mem_memread(a_mem_memread), .mem_memwrite(a_mem_memwrite),
    .mem_regwrite(a_mem_regwrite), .wb_regwrite(a_wb_regwrite), .wb_memtoreg(a_wb_memtoreg),
    .stall_count(a_stall_count)
  );

  pipelined_control_unit #(.LOAD_USE_BUBBLES(2), .ENABLE_JUMP(0), .CNT_W(2)) dut_b (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_opcode(id_opcode), .id_rs1(id_rs1),
    .id_rs2(id_rs2), .id_rd(id_rd), .branch_taken(branch_taken), .stall(b_stall), .flush(b_flush),
    .ex_alusrc(b_ex_alusrc), .ex_branch(b_ex_branch), .ex_jump(b_ex_jump), .ex_memread(b_ex_memread),
    .ex_memwrite(b_ex_memwrite), .ex_aluop(b_ex_aluop), .ex_rd(b_ex_rd), .mem_rd(b_mem_rd),
    .wb_rd(b_wb_rd), .mem_memread(b_mem_memread), .mem_memwrite(b_mem_memwrite),
    .mem_regwrite(b_mem_regwrite), .wb_regwrite(b_wb_regwrite), .wb_memtoreg(b_wb_memtoreg),
    .stall_count(b_stall_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic id(input logic v, input logic [6:0] op, input logic [4:0] r1, input logic [4:0] r2,
                    input logic [4:0] rd);
    id_valid = v; id_opcode = op; id_rs1 = r1; id_rs2 = r2; id_rd = rd;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b0; branch_taken = 1'b0;
    id(1'b1, LD, 5'd0, 5'd0, 5'd5);
    #10;
    chk("reset_ex_memread", a_ex_memread, 0);
    chk("reset_ex_rd", a_ex_rd, 0);
    chk("reset_wb_regwrite", a_wb_regwrite, 0);
    chk("reset_stall", a_stall, 0);
    chk("reset_flush", a_flush, 0);
    chk("reset_count", a_stall_count, 0);
    reset = 1'b1;
    id(1'b1, RT, 5'd1, 5'd2, 5'd3);
    chk("pipe_stall0", a_stall, 0);
    tick();
    chk("pipe_ex_aluop", a_ex_aluop, 2'b10);
    chk("pipe_ex_alusrc", a_ex_alusrc, 0);
    chk("pipe_ex_rd", a_ex_rd, 3);
    id(1'b1, LD, 5'd1, 5'd0, 5'd5);
    chk("pipe_stall1", a_stall, 0);
    tick();
    chk("pipe_mem_regwrite", a_mem_regwrite, 1);
    chk("pipe_mem_rd", a_mem_rd, 3);
    chk("pipe_ex_memread", a_ex_memread, 1);
    id(1'b1, ST, 5'd6, 5'd7, 5'd0);
    chk("pipe_store_stall_a", a_stall, 0);
    chk("pipe_store_stall_b", b_stall, 0);
    tick();
    chk("pipe_wb_regwrite", a_wb_regwrite, 1);
    chk("pipe_wb_rd", a_wb_rd, 3);
    chk("pipe_ex_memwrite", a_ex_memwrite, 1);
    chk("pipe_ex_alusrc_st", a_ex_alusrc, 1);
    id(1'b0, 7'd0, 5'd0, 5'd0, 5'd0);
    tick();
    chk("pipe_wb_memtoreg", a_wb_memtoreg, 1);
    chk("pipe_wb_rd_ld", a_wb_rd, 5);

    id(1'b1, LD, 5'd1, 5'd0, 5'd5);
    tick();
    id(1'b1, RT, 5'd1, 5'd5, 5'd8);
    chk("lu_stall_a", a_stall, 1);
    chk("lu_stall_b", b_stall, 1);
    tick();
    chk("lu_bubble_rd", a_ex_rd, 0);
    chk("lu_bubble_aluop", a_ex_aluop, 0);
    chk("lu_count_a1", a_stall_count, 1);
    chk("lu_stall_a_off", a_stall, 0);
    chk("lu_stall_b_2nd", b_stall, 1);
    chk("lu_count_b1", b_stall_count, 1);
    tick();
    chk("lu_ex_rd_a", a_ex_rd, 8);
    chk("lu_ex_aluop_a", a_ex_aluop, 2'b10);
    chk("lu_count_a_hold", a_stall_count, 1);
    chk("lu_count_b2", b_stall_count, 2);
    chk("lu_stall_b_off", b_stall, 0);
    chk("lu_ex_rd_b_bubble", b_ex_rd, 0);
    tick();
    chk("lu_ex_rd_b", b_ex_rd, 8);
    id(1'b0, 7'd0, 5'd0, 5'd0, 5'd0);

    id(1'b1, LD, 5'd1, 5'd0, 5'd0);
    tick();
    chk("nf_ex_memread", a_ex_memread, 1);
    chk("nf_ex_rd0", a_ex_rd, 0);
    id(1'b1, RT, 5'd0, 5'd0, 5'd4);
    chk("nf_rd0_stall_a", a_stall, 0);
    chk("nf_rd0_stall_b", b_stall, 0);
    tick();
    chk("nf_mem_regwrite_rd0", a_mem_regwrite, 0);
    id(1'b1, LD, 5'd1, 5'd0, 5'd5);
    tick();
    id(1'b1, LUI, 5'd5, 5'd5, 5'd6);
    chk("nf_lui_stall_a", a_stall, 0);
    chk("nf_lui_stall_b", b_stall, 0);
    tick();
    chk("nf_lui_aluop_a", a_ex_aluop, 2'b11);
    chk("nf_lui_alusrc_a", a_ex_alusrc, 1);
    chk("nf_lui_rd_a", a_ex_rd, 6);
    chk("nf_lui_aluop_b", b_ex_aluop, 0);
    chk("nf_lui_rd_b", b_ex_rd, 0);

    id(1'b1, LD, 5'd1, 5'd0, 5'd5);
    tick();
    branch_taken = 1'b1;
    id(1'b1, RT, 5'd0, 5'd5, 5'd9);
    chk("bp_flush", a_flush, 1);
    chk("bp_stall_a", a_stall, 0);
    chk("bp_stall_b", b_stall, 0);
    tick();
    branch_taken = 1'b0;
    chk("bp_ex_rd", a_ex_rd, 0);
    chk("bp_ex_aluop", a_ex_aluop, 0);
    chk("bp_guard_mem_memread", a_mem_memread, 0);
    chk("bp_count_a", a_stall_count, 1);
    chk("bp_count_b", b_stall_count, 2);
    id(1'b0, 7'd0, 5'd0, 5'd0, 5'd0);
    chk("bp_flush_off", a_flush, 0);

    id(1'b1, JAL, 5'd0, 5'd0, 5'd1);
    tick();
    chk("jal_ex_jump_a", a_ex_jump, 1);
    chk("jal_ex_jump_b", b_ex_jump, 0);
    chk("jal_ex_rd_b", b_ex_rd, 0);
    id(1'b0, 7'd0, 5'd0, 5'd0, 5'd0);
    tick();
    chk("jal_mem_regwrite_a", a_mem_regwrite, 1);
    chk("jal_mem_rd_a", a_mem_rd, 1);
    chk("jal_mem_regwrite_b", b_mem_regwrite, 0);
    id(1'b1, BR, 5'd1, 5'd2, 5'd0);
    tick();
    chk("br_ex_branch_a", a_ex_branch, 1);
    chk("br_ex_aluop_a", a_ex_aluop, 2'b01);
    chk("br_ex_branch_b", b_ex_branch, 1);
    id(1'b1, IA, 5'd1, 5'd0, 5'd2);
    tick();
    chk("ia_ex_alusrc", a_ex_alusrc, 1);
    chk("ia_ex_aluop", a_ex_aluop, 0);
    id(1'b0, 7'd0, 5'd0, 5'd0, 5'd0);
    tick();
    chk("ia_mem_regwrite", a_mem_regwrite, 1);

    for (int k = 0; k < 2; k++) begin
      id(1'b1, LD, 5'd1, 5'd0, 5'd5);
      tick();
      id(1'b1, RT, 5'd5, 5'd0, 5'd7);
      chk("sat_stall_a", a_stall, 1);
      tick();
      chk("sat_stall_b", b_stall, 1);
      tick();
      id(1'b0, 7'd0, 5'd0, 5'd0, 5'd0);
      tick();
      chk("sat_count_a", a_stall_count, 32'(2 + k));
      chk("sat_count_b", b_stall_count, 3);
    end

    id(1'b1, LD, 5'd1, 5'd0, 5'd5);
    tick();
    id(1'b0, 7'd0, 5'd0, 5'd0, 5'd0);
    tick();
    chk("mr_pre_mem_memread", a_mem_memread, 1);
    #1 reset = 1'b0;
    #1;
    chk("mr_mem_memread", a_mem_memread, 0);
    chk("mr_mem_rd", a_mem_rd, 0);
    chk("mr_wb_regwrite", a_wb_regwrite, 0);
    chk("mr_count_a", a_stall_count, 0);
    chk("mr_count_b", b_stall_count, 0);
    #2 reset = 1'b1;
    id(1'b1, RT, 5'd1, 5'd2, 5'd3);
    tick();
    id(1'b0, 7'd0, 5'd0, 5'd0, 5'd0);
    chk("mr_wb_bubble", a_wb_regwrite, 0);
    tick();
    tick();
    chk("mr_wb_regwrite", a_wb_regwrite, 1);
    chk("mr_wb_rd", a_wb_rd, 3);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/pipelined_control_unit.md
Name: pipelined_control_unit

Overview:
Parametrised successor to the single-cycle decoder: decodes the opcode in ID and carries the control word through ID/EX, EX/MEM and MEM/WB registers. It also contains load-use hazard detection, branch flush and a stall performance counter, and optionally decodes JAL, JALR, LUI and AUIPC. It sits beside the 5-stage datapath and drives that datapath's stage-local controls directly.

Parameters:
REG_ADDR_W, 5, register-index width.
ALUOP_W, 2, ALU-op field width; must be >=2. Codes are zero-extended.
LOAD_USE_BUBBLES, 1, load-use bubbles inserted: 1 = MEM->EX forwarding exists; 2 = no forwarding, so MEM-stage loads are also checked.
ENABLE_JUMP, 1, 1 = decode JAL/JALR/LUI/AUIPC; 0 = treat them as unknown opcodes.
CNT_W, 16, stall-counter width.

Ports:
clk  in  1  rising-edge clock
reset  in  1  asynchronous active-low reset
id_valid  in  1  ID holds a real instruction
id_opcode  in  7  opcode of the instruction in ID
id_rs1  in  REG_ADDR_W  source register 1 of the ID instruction
id_rs2  in  REG_ADDR_W  source register 2 of the ID instruction
id_rd  in  REG_ADDR_W  destination register of the ID instruction
branch_taken  in  1  EX resolved a taken branch or jump
stall  out  1  freeze PC and IF/ID; ID/EX receives a bubble
flush  out  1  squash IF/ID
ex_alusrc, ex_branch, ex_jump, ex_memread, ex_memwrite  out  1 each  EX-stage controls
ex_aluop  out  ALUOP_W  EX-stage ALU op
ex_rd, mem_rd, wb_rd  out  REG_ADDR_W  per-stage destination register
mem_memread, mem_memwrite, mem_regwrite  out  1 each  MEM-stage controls
wb_regwrite, wb_memtoreg  out  1 each  WB-stage controls
stall_count  out  CNT_W  saturating count of stall cycles

Behaviour:
- Decode (combinational, in ID). Fields are alusrc/memtoreg/regwrite/memread/memwrite/branch/jump/aluop:
  - 0000011 load: 1/1/1/1/0/0/0/00
  - 0100011 store: 1/0/0/0/1/0/0/00
  - 0110011 R-type: 0/0/1/0/0/0/0/10
  - 1100011 branch: 0/0/0/0/0/1/0/01
  - 0010011 I-ALU: 1/0/1/0/0/0/0/00
  - ENABLE_JUMP=1 only:
    - 1101111 JAL: 0/0/1/0/0/0/1/00
    - 1100111 JALR: 1/0/1/0/0/0/1/00
    - 0110111 LUI: 1/0/1/0/0/0/0/11
    - 0010111 AUIPC: 1/0/1/0/0/0/0/11
  - Any other opcode, or id_valid=0: all zero (bubble). No X outputs, ever.
- Regwrite qualifier: any stage with rd==0 has its regwrite forced to 0 when registered.
- Hazard (combinational): stall=1 when id_valid, AND ID reads the matching source, AND one of:
  - ex_memread && ex_rd!=0 && ex_rd matches id_rs1 or id_rs2;
  - LOAD_USE_BUBBLES==2 && mem_memread && mem_rd!=0 && mem_rd matches.
  - R-type, branch and store read rs1 and rs2. Load, I-ALU and JALR read rs1 only. JAL, LUI and AUIPC read neither.
- Flush: flush=branch_taken. When flush=1, stall is forced to 0 (flush has priority).
- Pipeline registers, one cycle per stage (a decoded word reaches EX at the next edge, MEM +1, WB +2):
  - ID/EX loads the decoded word, or all zeros if stall or branch_taken.
  - EX/MEM loads from EX, except that it loads zeros when branch_taken=1 and ex_jump=0 and ex_branch=0. That cannot occur in legal use; it is a guard only.
  - MEM/WB loads from MEM unconditionally.
- stall_count: increments on each edge where stall=1; holds at 2^CNT_W-1.
- Reset (reset=0, asynchronous): every stage register and stall_count clear to 0, so all ex_/mem_/wb_ outputs are 0. stall and flush are combinational from inputs and cleared state, so both read 0 while reset is held. Deasserting reset mid-stream gives three bubble stages, then normal flow.
- Simultaneous stall and branch_taken: flush wins, no stall is counted, and ID/EX gets a bubble.

Test Plan:
- Reset mid-run: pulse reset=0 while a load is in MEM -> all ex_/mem_/wb_ outputs are 0 immediately (asynchronous) and stall_count=0.
- Pipelining: issue R-type (rd=3), then load (rd=5), then store -> R-type shows ex_aluop=10 at cycle 1 and wb_regwrite=1, wb_rd=3 at cycle 3. The load gives wb_memtoreg=1 at cycle 4.
- Load-use, LOAD_USE_BUBBLES=1: load rd=5 in EX, ID = R-type with rs2=5 -> stall=1 for exactly one cycle, ID/EX bubble, stall_count=1. With LOAD_USE_BUBBLES=2 -> stall=1 for two cycles, stall_count=2.
- No false stall: load rd=0 followed by rs1=0 user -> stall=0. Load rd=5 followed by LUI (ENABLE_JUMP=1) -> stall=0.
- Branch priority: branch_taken=1 while a load-use hazard is present -> flush=1, stall=0, next ex_* all 0, stall_count unchanged.
- Decode gating: opcode 1101111 with ENABLE_JUMP=0 -> all controls 0. With ENABLE_JUMP=1 -> ex_jump=1 and mem_regwrite=1 one cycle later. Counter saturation with CNT_W=2: holds at 3.
